// File: rtl/spi_reg_bank.sv
// Command/register stage behind spi_slave: decodes address/data frames, holds the
// register bank and supplies read data back to the shifter on tx_byte_o.
module spi_reg_bank #(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [7:0]  DEVICE_ID = 8'hA7,
    parameter logic [7:0]  IDLE_BYTE = 8'h0A
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_n_i,
    input  logic [7:0]            rx_byte_i,
    input  logic                  rx_valid_i,
    output logic [7:0]            tx_byte_o,
    output logic                  wr_strobe_o,
    output logic [6:0]            wr_addr_o,
    output logic [7:0]            wr_data_o,
    output logic                  addr_err_o,
    output logic [NUM_REGS*8-1:0] regs_flat_o
);

    typedef enum logic [1:0] {StCmd, StWrite, StRead} state_e;

    state_e     state_q, state_d;
    logic [6:0] ptr_q, ptr_d;
    logic [7:0] tx_q, tx_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       addr_err_q, addr_err_d;
    logic       wr_en;

    // Register 0 is the constant device ID, so only 1..NUM_REGS-1 are storage.
    logic [7:0] bank_q [1:NUM_REGS-1];

    logic       cs_meta_q, cs_sync_q, cs_prev_q;
    logic       cs_edge;
    logic [6:0] ptr_inc;
    logic [7:0] rd_cmd, rd_next;
    logic       ptr_in_range;

    // cs_n is asynchronous to clk: two-flop synchronizer, third flop for edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
            cs_prev_q <= 1'b1;
        end else begin
            cs_meta_q <= cs_n_i;
            cs_sync_q <= cs_meta_q;
            cs_prev_q <= cs_sync_q;
        end
    end

    assign cs_edge      = cs_sync_q ^ cs_prev_q;
    assign ptr_inc      = ptr_q + 7'd1;
    assign ptr_in_range = {1'b0, ptr_q} < 8'(NUM_REGS);

    // Read muxes: command address (first read byte) and post-increment pointer.
    always_comb begin
        rd_cmd  = 8'h00;
        rd_next = 8'h00;
        if (rx_byte_i[6:0] == 7'd0) begin
            rd_cmd = DEVICE_ID;
        end
        if (ptr_inc == 7'd0) begin
            rd_next = DEVICE_ID;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rx_byte_i[6:0] == 7'(i)) begin
                rd_cmd = bank_q[i];
            end
            if (ptr_inc == 7'(i)) begin
                rd_next = bank_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        tx_d        = tx_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        addr_err_d  = 1'b0;
        wr_en       = 1'b0;

        if (rx_valid_i) begin
            unique case (state_q)
                StCmd: begin
                    ptr_d = rx_byte_i[6:0];
                    if (rx_byte_i[7]) begin
                        state_d = StRead;
                        tx_d    = rd_cmd;
                    end else begin
                        state_d = StWrite;
                    end
                end
                StWrite: begin
                    if (ptr_in_range && (ptr_q != 7'd0)) begin
                        wr_en       = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        wr_data_d   = rx_byte_i;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                    ptr_d = ptr_inc;
                end
                StRead: begin
                    addr_err_d = !ptr_in_range;
                    ptr_d      = ptr_inc;
                    tx_d       = rd_next;
                end
                default: begin
                    state_d = StCmd;
                end
            endcase
        end

        // A chip-select edge ends the frame; it overrides any read preload.
        if (cs_edge) begin
            state_d = StCmd;
            tx_d    = IDLE_BYTE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StCmd;
            ptr_q       <= 7'd0;
            tx_q        <= IDLE_BYTE;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 7'd0;
            wr_data_q   <= 8'h00;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            tx_q        <= tx_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            addr_err_q  <= addr_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                bank_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (ptr_q == 7'(i)) begin
                    bank_q[i] <= rx_byte_i;
                end
            end
        end
    end

    always_comb begin
        regs_flat_o[7:0] = DEVICE_ID;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_flat_o[8*i +: 8] = bank_q[i];
        end
    end

    assign tx_byte_o   = tx_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign addr_err_o  = addr_err_q;

endmodule
